// File: rtl/dca_matrix_store_engine_pkg.sv
// Shared definitions for the DCA LSU matrix store engine: FSM encoding and
// the page size that AXI bursts must never cross.
package dca_matrix_store_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAN  = 2'd1,
    ST_BEAT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int unsigned PAGE_BITS  = 12;
  localparam int unsigned PAGE_BYTES = 1 << PAGE_BITS;

endpackage

// File: rtl/dca_matrix_store_engine_if.sv
// Instruction, write-data, write-request and response channels of the
// matrix store engine; slave is the engine side, master the environment.
interface dca_matrix_store_engine_if #(
  parameter int unsigned BW_AXI_DATA = 32,
  parameter int unsigned BW_AXI_ADDR = 32,
  parameter int unsigned BW_DIM      = 12
);
  localparam int unsigned BW_STRB = BW_AXI_DATA / 8;

  logic                   inst_valid;
  logic                   inst_ready;
  logic [BW_AXI_ADDR-1:0] inst_addr;
  logic [BW_AXI_ADDR-1:0] inst_stride;
  logic [BW_DIM-1:0]      inst_num_row_m1;
  logic [BW_DIM-1:0]      inst_num_beat_m1;

  logic                   wdata_valid;
  logic                   wdata_ready;
  logic [BW_AXI_DATA-1:0] wdata;
  logic [BW_STRB-1:0]     wstrb;

  logic                   req_valid;
  logic                   req_ready;
  logic [BW_AXI_ADDR-1:0] req_addr;
  logic [7:0]             req_len;
  logic [BW_AXI_DATA-1:0] req_wdata;
  logic [BW_STRB-1:0]     req_wstrb;
  logic                   req_last;

  logic                   rsp_valid;
  logic                   rsp_error;
  logic                   rsp_ready;

  modport slave (
    input  inst_valid, inst_addr, inst_stride, inst_num_row_m1, inst_num_beat_m1,
    output inst_ready,
    input  wdata_valid, wdata, wstrb,
    output wdata_ready,
    output req_valid, req_addr, req_len, req_wdata, req_wstrb, req_last,
    input  req_ready,
    input  rsp_valid, rsp_error,
    output rsp_ready
  );

  modport master (
    output inst_valid, inst_addr, inst_stride, inst_num_row_m1, inst_num_beat_m1,
    input  inst_ready,
    output wdata_valid, wdata, wstrb,
    input  wdata_ready,
    input  req_valid, req_addr, req_len, req_wdata, req_wstrb, req_last,
    output req_ready,
    output rsp_valid, rsp_error,
    input  rsp_ready
  );

endinterface

// File: rtl/dca_matrix_store_engine_burst_len_calc.sv
// Beats for the next burst: the smallest of the burst cap, the beats left in
// the current row and the beats remaining before the next 4 KB page.
module dca_burst_len_calc
  import dca_matrix_store_engine_pkg::*;
#(
  parameter int unsigned BW_AXI_DATA   = 32,
  parameter int unsigned BW_DIM        = 12,
  parameter int unsigned MAX_BURST_LEN = 16
) (
  input  logic [PAGE_BITS-1:0] page_off_i,
  input  logic [BW_DIM:0]      row_left_i,
  output logic [8:0]           beats_o
);

  localparam int unsigned BEAT_SHIFT = $clog2(BW_AXI_DATA / 8);
  localparam int unsigned BW_PAGE    = PAGE_BITS + 1;
  localparam int unsigned BW_CMP     = (BW_DIM + 1 > BW_PAGE) ? BW_DIM + 1 : BW_PAGE;

  logic [BW_PAGE-1:0] page_bytes_left;
  logic [BW_CMP-1:0]  to_page;
  logic [BW_CMP-1:0]  row_left;
  logic [BW_CMP-1:0]  lim;

  always_comb begin
    page_bytes_left = BW_PAGE'(PAGE_BYTES) - BW_PAGE'(page_off_i);
    to_page         = BW_CMP'(page_bytes_left >> BEAT_SHIFT);
    row_left        = BW_CMP'(row_left_i);
    lim             = BW_CMP'(MAX_BURST_LEN);
    if (row_left < lim) lim = row_left;
    if (to_page < lim)  lim = to_page;
    beats_o = 9'(lim);
  end

endmodule

// File: rtl/dca_matrix_store_engine.sv
// Matrix store engine: splits a strided rows x beats store into page-safe
// bursts, streams write data through, and tracks outstanding responses.
module dca_matrix_store_engine
  import dca_matrix_store_engine_pkg::*;
#(
  parameter int unsigned BW_AXI_DATA     = 32,
  parameter int unsigned BW_AXI_ADDR     = 32,
  parameter int unsigned BW_DIM          = 12,
  parameter int unsigned MAX_BURST_LEN   = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     rstnn,
  dca_matrix_store_engine_if.slave bus,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int unsigned BEAT_SHIFT = $clog2(BW_AXI_DATA / 8);
  localparam int unsigned BW_ROW     = BW_DIM + 1;
  localparam int unsigned BW_OUT     = $clog2(MAX_OUTSTANDING + 1);

  state_e                 state_q, state_d;
  logic [BW_AXI_ADDR-1:0] row_base_q, row_base_d;
  logic [BW_AXI_ADDR-1:0] cur_addr_q, cur_addr_d;
  logic [BW_AXI_ADDR-1:0] stride_q, stride_d;
  logic [BW_AXI_ADDR-1:0] burst_addr_q, burst_addr_d;
  logic [BW_DIM-1:0]      rows_left_q, rows_left_d;
  logic [BW_DIM-1:0]      num_beat_m1_q, num_beat_m1_d;
  logic [BW_ROW-1:0]      row_left_q, row_left_d;
  logic [8:0]             burst_beats_q, burst_beats_d;
  logic [8:0]             beat_cnt_q, beat_cnt_d;
  logic [BW_OUT-1:0]      outst_q, outst_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic [8:0]             plan_beats;
  logic [BW_ROW-1:0]      row_rem;
  logic [BW_AXI_ADDR-1:0] burst_bytes;
  logic                   beat_fire;
  logic                   last_beat;
  logic                   burst_end;
  logic                   rsp_dec;

  dca_burst_len_calc #(
    .BW_AXI_DATA  (BW_AXI_DATA),
    .BW_DIM       (BW_DIM),
    .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_burst_len_calc (
    .page_off_i(cur_addr_q[PAGE_BITS-1:0]),
    .row_left_i(row_left_q),
    .beats_o   (plan_beats)
  );

  assign last_beat   = (state_q == ST_BEAT) && (beat_cnt_q == burst_beats_q - 9'd1);
  assign beat_fire   = (state_q == ST_BEAT) && bus.wdata_valid && bus.req_ready;
  assign burst_end   = beat_fire && last_beat;
  // A response with nothing outstanding is dropped so the counter cannot underflow.
  assign rsp_dec     = bus.rsp_valid && (outst_q != '0);
  assign row_rem     = row_left_q - BW_ROW'(burst_beats_q);
  assign burst_bytes = BW_AXI_ADDR'(burst_beats_q) << BEAT_SHIFT;

  assign bus.req_addr  = burst_addr_q;
  assign bus.req_len   = 8'(burst_beats_q - 9'd1);
  assign bus.req_wdata = bus.wdata;
  assign bus.req_wstrb = bus.wstrb;
  assign bus.req_last  = last_beat;
  assign bus.rsp_ready = 1'b1;

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign error = error_q;

  // Next-state, handshake outputs and datapath updates.
  always_comb begin
    state_d         = state_q;
    row_base_d      = row_base_q;
    cur_addr_d      = cur_addr_q;
    stride_d        = stride_q;
    burst_addr_d    = burst_addr_q;
    rows_left_d     = rows_left_q;
    num_beat_m1_d   = num_beat_m1_q;
    row_left_d      = row_left_q;
    burst_beats_d   = burst_beats_q;
    beat_cnt_d      = beat_cnt_q;
    outst_d         = outst_q;
    done_d          = 1'b0;
    error_d         = error_q;
    bus.inst_ready  = 1'b0;
    bus.wdata_ready = 1'b0;
    bus.req_valid   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.inst_ready = 1'b1;
        if (bus.inst_valid) begin
          row_base_d    = bus.inst_addr;
          cur_addr_d    = bus.inst_addr;
          stride_d      = bus.inst_stride;
          rows_left_d   = bus.inst_num_row_m1;
          num_beat_m1_d = bus.inst_num_beat_m1;
          row_left_d    = BW_ROW'(bus.inst_num_beat_m1) + BW_ROW'(1);
          error_d       = 1'b0;
          state_d       = ST_PLAN;
        end
      end
      ST_PLAN: begin
        if (outst_q != BW_OUT'(MAX_OUTSTANDING)) begin
          burst_addr_d  = cur_addr_q;
          burst_beats_d = plan_beats;
          beat_cnt_d    = 9'd0;
          state_d       = ST_BEAT;
        end
      end
      ST_BEAT: begin
        bus.req_valid   = bus.wdata_valid;
        bus.wdata_ready = bus.req_ready;
        if (beat_fire) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
        end
        if (burst_end) begin
          if (row_rem != '0) begin
            row_left_d = row_rem;
            cur_addr_d = cur_addr_q + burst_bytes;
            state_d    = ST_PLAN;
          end else if (rows_left_q != '0) begin
            rows_left_d = rows_left_q - BW_DIM'(1);
            row_base_d  = row_base_q + stride_q;
            cur_addr_d  = row_base_q + stride_q;
            row_left_d  = BW_ROW'(num_beat_m1_q) + BW_ROW'(1);
            state_d     = ST_PLAN;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (outst_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case ({burst_end, rsp_dec})
      2'b10:   outst_d = outst_q + BW_OUT'(1);
      2'b01:   outst_d = outst_q - BW_OUT'(1);
      default: outst_d = outst_q;
    endcase

    if (rsp_dec && bus.rsp_error) error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q       <= ST_IDLE;
      row_base_q    <= '0;
      cur_addr_q    <= '0;
      stride_q      <= '0;
      burst_addr_q  <= '0;
      rows_left_q   <= '0;
      num_beat_m1_q <= '0;
      row_left_q    <= '0;
      burst_beats_q <= 9'd1;
      beat_cnt_q    <= '0;
      outst_q       <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_base_q    <= row_base_d;
      cur_addr_q    <= cur_addr_d;
      stride_q      <= stride_d;
      burst_addr_q  <= burst_addr_d;
      rows_left_q   <= rows_left_d;
      num_beat_m1_q <= num_beat_m1_d;
      row_left_q    <= row_left_d;
      burst_beats_q <= burst_beats_d;
      beat_cnt_q    <= beat_cnt_d;
      outst_q       <= outst_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

endmodule

// File: doc/dca_matrix_store_engine.md
DCA_MATRIX_STORE_ENGINE -- requirements
Module: dca_matrix_store_engine

Interface
REQ-001 SHALL have parameter BW_AXI_DATA, default 32: write data width in bits (32/64/128/256).
REQ-002 SHALL have parameter BW_AXI_ADDR, default 32: byte address width.
REQ-003 SHALL have parameter BW_DIM, default 12: row-count and beat-count field width.
REQ-004 SHALL have parameter MAX_BURST_LEN, default 16: maximum beats per burst (1..256).
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4: maximum unacknowledged bursts (1..16).
REQ-006 SHALL use one clock and an asynchronous active-low reset; ports as below.
REQ-007 clk  in  1  clock, all state rising-edge.
REQ-008 rstnn  in  1  asynchronous active-low reset.
REQ-009 inst_valid / inst_ready  in/out  1  matrix store instruction handshake.
REQ-010 inst_addr  in  BW_AXI_ADDR  first-row byte address, aligned to BW_AXI_DATA/8.
REQ-011 inst_stride  in  BW_AXI_ADDR  byte distance between row starts, aligned likewise.
REQ-012 inst_num_row_m1 / inst_num_beat_m1  in  BW_DIM  rows-1 / beats-per-row-1.
REQ-013 wdata_valid / wdata_ready  in/out  1; wdata  in  BW_AXI_DATA; wstrb  in  BW_AXI_DATA/8  write data stream.
REQ-014 req_valid / req_ready  out/in  1  per-beat write request handshake.
REQ-015 req_addr  out  BW_AXI_ADDR; req_len  out  8 (beats-1); req_wdata  out  BW_AXI_DATA; req_wstrb  out  BW_AXI_DATA/8; req_last  out  1.
REQ-016 rsp_valid  in  1; rsp_error  in  1  write response; rsp_ready  out  1, constant 1.
REQ-017 busy  out  1; done  out  1 (one-cycle pulse); error  out  1 (sticky).

Function
REQ-018 SHALL implement states IDLE, PLAN, BEAT, DRAIN.
REQ-019 IDLE: inst_ready=1; inst_valid captures all fields, clears error, -> PLAN next cycle.
REQ-020 PLAN (1 cycle): burst beats = min(MAX_BURST_LEN, beats left in row, beats to next 4 KB boundary); if outstanding==MAX_OUTSTANDING, stay in PLAN; else -> BEAT.
REQ-021 BEAT: req_valid = wdata_valid; wdata_ready = req_ready; wdata/wstrb pass through combinationally; req_addr/req_len hold burst values for every beat.
REQ-022 req_last SHALL be 1 on the final beat of each burst; its acceptance increments outstanding.
REQ-023 After a burst: remaining row beats >0 -> PLAN at address+burst bytes; row done and rows remain -> PLAN at row_base+inst_stride; all done -> DRAIN.
REQ-024 DRAIN: wait outstanding==0, pulse done, -> IDLE.
REQ-025 Each rsp_valid SHALL decrement outstanding; simultaneous increment and decrement leave it unchanged.
REQ-026 rsp_valid with outstanding==0 SHALL be ignored, counter not underflowing.
REQ-027 rsp_error=1 with rsp_valid SHALL set error until the next accepted instruction; the transfer continues to completion.
REQ-028 Address arithmetic SHALL be modulo 2^BW_AXI_ADDR (wrap-around permitted, no flag).
REQ-029 busy = (state != IDLE).
REQ-030 All state, counters and addresses SHALL be flops.

Reset
REQ-031 On rstnn=0, SHALL enter IDLE immediately, including mid-burst, discarding the instruction.
REQ-032 Reset values: outstanding=0, error=0, done=0, busy=0, req_valid=0, wdata_ready=0, inst_ready=1 after release.

Structure
REQ-033 State encoding and the 4 KB boundary constant SHALL live in the shared DCA LSU package.
REQ-034 Burst-length computation SHALL be the sub-module dca_burst_len_calc (purely combinational).

Verification
REQ-035 32-bit, addr 0x1000, 1 row, 4 beats -> one burst req_addr 0x1000, req_len 3, last on beat 4, done after 1 response.
REQ-036 32-bit, addr 0x0FF8, 1 row, 8 beats -> bursts 0x0FF8 len 1 and 0x1000 len 5.
REQ-037 3 rows x 20 beats, stride 0x100, addr 0x2000, MAX_BURST_LEN 16 -> bursts 0x2000/15, 0x2040/3, 0x2100/15, 0x2140/3, 0x2200/15, 0x2240/3.
REQ-038 MAX_OUTSTANDING 2, responses withheld -> third burst held in PLAN; one response -> issues next cycle.
REQ-039 rsp_error on 2nd of 3 responses -> error=1 at done; new instruction clears it.
REQ-040 rstnn low during beat 2 of a 4-beat burst -> outputs at reset values same cycle; new instruction runs normally.
